// File: rtl/div_unit.sv
// Sequential restoring divider for DIV/DIVU. Produces one quotient bit per
// cycle over WIDTH cycles, then a sign-fix cycle. Quotient lands in lo and
// remainder in hi, matching the multiplier's HI/LO convention.
//
// Ports:
//   clk       rising-edge clock
//   rst       synchronous active-high reset; aborts any operation in flight
//   start     request, accepted only when idle and not in the done cycle
//   dividend  numerator, captured at the accepting edge
//   divisor   denominator, captured at the accepting edge
//   busy      high from the accepting edge until the done edge
//   done      one-cycle pulse; hi/lo/div_zero valid while high
//   div_zero  divisor was zero; holds until the next accepted start
//   lo        quotient; holds until the next completion
//   hi        remainder; holds until the next completion
module div_unit #(
    parameter int unsigned WIDTH  = 32,
    parameter bit          SIGNED = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] hi
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [1:0] {StIdle, StRun, StFix, StZero} state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH:0]    rem_q, rem_d;
    logic [WIDTH-1:0]  dvs_q, dvs_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              sa_q, sa_d;
    logic              sb_q, sb_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              dz_q, dz_d;

    logic [WIDTH:0]    rem_shift;
    logic              a_neg, b_neg;

    always_comb begin
        state_d   = state_q;
        quo_d     = quo_q;
        rem_d     = rem_q;
        dvs_d     = dvs_q;
        cnt_d     = cnt_q;
        sa_d      = sa_q;
        sb_d      = sb_q;
        lo_d      = lo_q;
        hi_d      = hi_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        dz_d      = dz_q;
        // The remainder is always below the divisor, so its top bit is zero
        // before the shift; the cast keeps the low WIDTH+1 bits.
        rem_shift = (WIDTH + 1)'({rem_q, quo_q[WIDTH-1]});
        a_neg     = SIGNED && dividend[WIDTH-1];
        b_neg     = SIGNED && divisor[WIDTH-1];

        unique case (state_q)
            StIdle: begin
                // The done cycle also sits in StIdle; start is ignored there.
                if (start && !done_q) begin
                    dz_d   = 1'b0;
                    busy_d = 1'b1;
                    if (divisor == '0) begin
                        state_d = StZero;
                    end else begin
                        // Negating the most negative value yields 2^(W-1),
                        // which is the correct unsigned magnitude.
                        quo_d   = a_neg ? -dividend : dividend;
                        dvs_d   = b_neg ? -divisor : divisor;
                        sa_d    = a_neg;
                        sb_d    = b_neg;
                        rem_d   = '0;
                        cnt_d   = '0;
                        state_d = StRun;
                    end
                end
            end
            StRun: begin
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
                if (rem_shift >= {1'b0, dvs_q}) begin
                    rem_d    = rem_shift - {1'b0, dvs_q};
                    quo_d[0] = 1'b1;
                end else begin
                    rem_d = rem_shift;
                end
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
            end
            StFix: begin
                lo_d    = (sa_q != sb_q) ? -quo_q : quo_q;
                hi_d    = sa_q ? -rem_q[WIDTH-1:0] : rem_q[WIDTH-1:0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            StZero: begin
                done_d  = 1'b1;
                dz_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            quo_q   <= '0;
            rem_q   <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            sa_q    <= 1'b0;
            sb_q    <= 1'b0;
            lo_q    <= '0;
            hi_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            sa_q    <= sa_d;
            sb_q    <= sb_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = dz_q;
    assign lo       = lo_q;
    assign hi       = hi_q;

endmodule

// File: tb/tb_div_unit.sv
// Bench for div_unit: a signed and an unsigned instance share all inputs and
// are checked every cycle against a cycle-timeline model that computes
// results with plain integer division.
module tb_div_unit;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [W-1:0]  dividend = '0;
    logic [W-1:0]  divisor = '0;

    logic          busy_s, done_s, dz_s;
    logic [W-1:0]  lo_s, hi_s;
    logic          busy_u, done_u, dz_u;
    logic [W-1:0]  lo_u, hi_u;

    always #5 clk = ~clk;

    div_unit #(.WIDTH(W), .SIGNED(1'b1)) u_s (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy_s), .done(done_s), .div_zero(dz_s), .lo(lo_s), .hi(hi_s)
    );

    div_unit #(.WIDTH(W), .SIGNED(1'b0)) u_u (
        .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
        .busy(busy_u), .done(done_u), .div_zero(dz_u), .lo(lo_u), .hi(hi_u)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference division: sgn selects two's-complement semantics.
    function automatic void ref_div(input logic [W-1:0] a, input logic [W-1:0] b,
                                    input bit sgn, output logic [W-1:0] q,
                                    output logic [W-1:0] r);
        longint sa, sb, q64, r64;
        if (sgn) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
        end else begin
            sa = longint'({32'b0, a});
            sb = longint'({32'b0, b});
        end
        q64 = sa / sb;
        r64 = sa % sb;
        q = q64[W-1:0];
        r = r64[W-1:0];
    endfunction

    // Model state describes the DUT outputs after the next rising edge.
    int           m_cnt = 0;
    bit           m_valid = 0;
    bit           m_busy = 0, m_done = 0, m_dz = 0, p_zero = 0;
    logic [W-1:0] m_lo_s = '0, m_hi_s = '0, m_lo_u = '0, m_hi_u = '0;
    logic [W-1:0] p_lo_s = '0, p_hi_s = '0, p_lo_u = '0, p_hi_u = '0;

    always @(negedge clk) begin
        bit was_done;
        if (m_valid) begin
            chk("busy_s", {31'b0, busy_s}, {31'b0, m_busy});
            chk("done_s", {31'b0, done_s}, {31'b0, m_done});
            chk("dz_s", {31'b0, dz_s}, {31'b0, m_dz});
            chk("lo_s", lo_s, m_lo_s);
            chk("hi_s", hi_s, m_hi_s);
            chk("busy_u", {31'b0, busy_u}, {31'b0, m_busy});
            chk("done_u", {31'b0, done_u}, {31'b0, m_done});
            chk("dz_u", {31'b0, dz_u}, {31'b0, m_dz});
            chk("lo_u", lo_u, m_lo_u);
            chk("hi_u", hi_u, m_hi_u);
        end
        // Inputs change only just after a rising edge, so the values seen now
        // are the ones the next rising edge samples.
        if (rst) begin
            m_cnt = 0; m_busy = 0; m_done = 0; m_dz = 0;
            m_lo_s = '0; m_hi_s = '0; m_lo_u = '0; m_hi_u = '0;
            m_valid = 1;
        end else begin
            was_done = m_done;
            m_done = 0;
            if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) begin
                    m_done = 1;
                    m_busy = 0;
                    if (p_zero) begin
                        m_dz = 1;
                    end else begin
                        m_lo_s = p_lo_s; m_hi_s = p_hi_s;
                        m_lo_u = p_lo_u; m_hi_u = p_hi_u;
                    end
                end
            end else if (!was_done && start) begin
                m_dz = 0;
                m_busy = 1;
                if (divisor == '0) begin
                    p_zero = 1;
                    m_cnt = 1;
                end else begin
                    p_zero = 0;
                    m_cnt = W + 1;
                    ref_div(dividend, divisor, 1'b1, p_lo_s, p_hi_s);
                    ref_div(dividend, divisor, 1'b0, p_lo_u, p_hi_u);
                end
            end
        end
    end

    function automatic logic [W-1:0] pick();
        case ($urandom % 6)
            0:       return '0;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return W'($urandom % 16);
            default: return W'($urandom);
        endcase
    endfunction

    // Issue one operation and check signed-instance results against literals.
    // lat is the number of edges from the accepting edge to the done edge.
    task automatic op(input logic [W-1:0] a, input logic [W-1:0] b, input int lat,
                      input logic [W-1:0] elo, input logic [W-1:0] ehi,
                      input logic edz, input bit toggle);
        int n, nb;
        @(posedge clk); #1;
        start = 1'b1; dividend = a; divisor = b;
        @(posedge clk); #1;
        start = 1'b0; dividend = W'($urandom); divisor = W'($urandom);
        n = 0; nb = 0;
        while (n < 60) begin
            @(negedge clk);
            n++;
            if (busy_s) nb++;
            if (done_s) break;
            @(posedge clk); #1;
            if (toggle) begin
                if (n == 5) start = 1'b1;
                if (n == 9) start = 1'b0;
                dividend = W'($urandom);
                divisor = W'($urandom);
            end
        end
        chk("latency", W'(n - 1), W'(lat));
        chk("busy_cycles", W'(nb), W'(lat));
        chk("lit_lo", lo_s, elo);
        chk("lit_hi", hi_s, ehi);
        chk("lit_dz", {31'b0, dz_s}, {31'b0, edz});
    endtask

    initial begin
        logic [W-1:0] q, r;
        int n_done;

        // Pin the reference model with hand-computed values.
        ref_div(32'd100, 32'd7, 1'b1, q, r);
        chk("model_q_100_7", q, 32'd14);
        chk("model_r_100_7", r, 32'd2);
        ref_div(32'hFFFF_FF9C, 32'd7, 1'b1, q, r);
        chk("model_q_m100_7", q, 32'hFFFF_FFF2);
        chk("model_r_m100_7", r, 32'hFFFF_FFFE);
        ref_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, q, r);
        chk("model_q_min_m1", q, 32'h8000_0000);
        chk("model_r_min_m1", r, 32'd0);
        ref_div(32'hFFFF_FFFF, 32'd2, 1'b0, q, r);
        chk("model_q_u", q, 32'h7FFF_FFFF);

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_busy", {31'b0, busy_s}, 32'd0);
        chk("rst_lo", lo_s, 32'd0);
        chk("rst_hi", hi_s, 32'd0);

        op(32'd100, 32'd7, 33, 32'd14, 32'd2, 1'b0, 1'b0);
        op(32'd5, 32'd0, 1, 32'd14, 32'd2, 1'b1, 1'b0);
        op(32'd6, 32'd3, 33, 32'd2, 32'd0, 1'b0, 1'b0);
        op(32'hFFFF_FF9C, 32'd7, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op(32'd100, 32'hFFFF_FFF9, 33, 32'hFFFF_FFF2, 32'd2, 1'b0, 1'b0);
        op(32'hFFFF_FF9C, 32'hFFFF_FFF9, 33, 32'd14, 32'hFFFF_FFFE, 1'b0, 1'b0);
        op(32'h8000_0000, 32'hFFFF_FFFF, 33, 32'h8000_0000, 32'd0, 1'b0, 1'b0);
        op(32'd3, 32'd10, 33, 32'd0, 32'd3, 1'b0, 1'b0);
        op(32'hFFFF_FFFF, 32'd2, 33, 32'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
        chk("lit_lo_u", lo_u, 32'h7FFF_FFFF);
        chk("lit_hi_u", hi_u, 32'd1);
        op(32'd1000, 32'd3, 33, 32'd333, 32'd1, 1'b0, 1'b1);

        // Reset during RUN: outputs clear and no done follows.
        @(posedge clk); #1;
        start = 1'b1; dividend = 32'd1234; divisor = 32'd1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("abort_busy", {31'b0, busy_s}, 32'd0);
        chk("abort_done", {31'b0, done_s}, 32'd0);
        chk("abort_lo", lo_s, 32'd0);
        chk("abort_hi", hi_s, 32'd0);
        n_done = 0;
        repeat (40) begin
            @(negedge clk);
            if (done_s) n_done++;
        end
        chk("abort_no_done", W'(n_done), 32'd0);
        op(32'd50, 32'd5, 33, 32'd10, 32'd0, 1'b0, 1'b0);

        // Randomised traffic, including held start and occasional reset.
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            start = ($urandom % 3) == 0;
            dividend = pick();
            divisor = pick();
            rst = ($urandom % 400) == 0;
        end
        @(posedge clk); #1;
        rst = 1'b0; start = 1'b0;
        repeat (40) @(posedge clk);
        @(negedge clk); #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
